// File: rtl/axi_wr_arb_2to1.sv
// ---------------------------------------------------------------------------
// axi_wr_arb_2to1
//
// Burst-granular round-robin arbiter driving the select of a 2:1 AXI4 write
// mux that shares one memory write port between two writers. AW, W and B
// traffic is observed on the shared master side. The select only changes
// once no write burst data is in flight. The AW gate (aw_en) throttles the
// current owner at hand-over and bounds the number of outstanding bursts.
//
// Parameters
//   C_MAX_BURSTS       AW bursts granted per tenure before forced hand-over (>=1)
//   C_MAX_OUTSTANDING  AW accepted whose W last has not yet completed (>=1)
//
// Ports
//   clk          clock
//   rst          asynchronous active-high reset
//   s00_awvalid  requester 0 AW valid (also its request)
//   s01_awvalid  requester 1 AW valid (also its request)
//   m_awready    shared master AW ready
//   m_wvalid     shared master W valid
//   m_wready     shared master W ready
//   m_wlast      shared master W last
//   m_bvalid     shared master B valid (bready tied high)
//   sel          registered mux select, 0 = s00, 1 = s01
//   aw_en        registered AW gate, ANDed into muxed awvalid/awready
//   busy         arbiter is not idle
//   err          sticky protocol error (W last or B without a pending burst)
//
// Build option
//   AXI_WR_ARB_BRESP_WAIT_EN  when defined, B responses are counted and the
//                             hand-over also waits for all outstanding B, so
//                             every B reaches the requester that issued it.
// ---------------------------------------------------------------------------
module axi_wr_arb_2to1 #(
   parameter int C_MAX_BURSTS      = 16,
   parameter int C_MAX_OUTSTANDING = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic s00_awvalid,
   input  logic s01_awvalid,
   input  logic m_awready,
   input  logic m_wvalid,
   input  logic m_wready,
   input  logic m_wlast,
   input  logic m_bvalid,
   output logic sel,
   output logic aw_en,
   output logic busy,
   output logic err
);

   localparam int WP_W = $clog2(C_MAX_OUTSTANDING + 1);
   localparam int BC_W = $clog2(C_MAX_BURSTS + 1);

   localparam logic [WP_W-1:0] WP_MAX  = WP_W'(C_MAX_OUTSTANDING);
   localparam logic [BC_W-1:0] BC_LAST = BC_W'(C_MAX_BURSTS - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              sel_q, sel_d;
   logic              last_sel_q, last_sel_d;
   logic              aw_en_q, aw_en_d;
   logic              err_q, err_d;
   logic [WP_W-1:0]   w_pend_q, w_pend_d;
   logic [BC_W-1:0]   burst_cnt_q, burst_cnt_d;

   logic              cur_req;
   logic              oth_req;
   logic              aw_hs;
   logic              w_hs;
   logic              w_err;
   logic              b_err;
   logic              b_idle;

   // Requests seen relative to the current owner.
   assign cur_req = sel_q ? s01_awvalid : s00_awvalid;
   assign oth_req = sel_q ? s00_awvalid : s01_awvalid;

   assign aw_hs = aw_en_q & cur_req & m_awready;
   assign w_hs  = m_wvalid & m_wready & m_wlast;

   // -----------------------------------------------------------------------
   // Bursts whose AW was accepted but whose W last has not completed.
   // A W last with nothing pending is a protocol violation: hold at zero
   // and flag it. AW and W last together cancel (a legal zero-latency
   // burst), so no error is raised in that case.
   // -----------------------------------------------------------------------
   always_comb begin
      w_pend_d = w_pend_q;
      w_err    = 1'b0;
      if (aw_hs && !w_hs) begin
         w_pend_d = w_pend_q + WP_W'(1);
      end else if (w_hs && !aw_hs) begin
         if (w_pend_q == '0) begin
            w_err = 1'b1;
         end else begin
            w_pend_d = w_pend_q - WP_W'(1);
         end
      end
   end

`ifdef AXI_WR_ARB_BRESP_WAIT_EN
   // -----------------------------------------------------------------------
   // Bursts whose data completed but whose B has not returned. Only
   // w_pend is bounded by aw_en, so this counter gets extra headroom and
   // saturates instead of wrapping if the slave stalls B for a long time.
   // -----------------------------------------------------------------------
   localparam int              BP_W   = WP_W + 2;
   localparam logic [BP_W-1:0] BP_MAX = '1;

   logic [BP_W-1:0] b_pend_q, b_pend_d;
   logic            b_hs;

   assign b_hs = m_bvalid;

   always_comb begin
      b_pend_d = b_pend_q;
      b_err    = 1'b0;
      if (w_hs && !b_hs) begin
         if (b_pend_q != BP_MAX) begin
            b_pend_d = b_pend_q + BP_W'(1);
         end
      end else if (b_hs && !w_hs) begin
         if (b_pend_q == '0) begin
            b_err = 1'b1;
         end else begin
            b_pend_d = b_pend_q - BP_W'(1);
         end
      end
   end

   assign b_idle = (b_pend_q == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         b_pend_q <= '0;
      end else begin
         b_pend_q <= b_pend_d;
      end
   end
`else
   // B is not part of the hand-over decision in this build.
   logic unused_bvalid;
   assign unused_bvalid = m_bvalid;
   assign b_err         = 1'b0;
   assign b_idle        = 1'b1;
`endif

   assign err_d = err_q | w_err | b_err;

   // -----------------------------------------------------------------------
   // Tenure state machine.
   // -----------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      last_sel_d  = last_sel_q;
      burst_cnt_d = burst_cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (s00_awvalid || s01_awvalid) begin
               // On a tie the requester that did not own the last tenure wins.
               sel_d       = (s00_awvalid && s01_awvalid) ? ~last_sel_q : s01_awvalid;
               burst_cnt_d = '0;
               state_d     = ST_GRANT;
            end
         end

         ST_GRANT: begin
            if (aw_hs) begin
               burst_cnt_d = burst_cnt_q + BC_W'(1);
            end
            // Tenure ends on the last allowed burst, or when the owner goes
            // quiet while the other side waits. With nobody asking, the
            // owner keeps the port so a returning owner pays no bubble.
            if ((aw_hs && (burst_cnt_q == BC_LAST)) || (!cur_req && oth_req)) begin
               state_d = ST_DRAIN;
            end
         end

         ST_DRAIN: begin
            if ((w_pend_q == '0) && b_idle) begin
               last_sel_d = sel_q;
               state_d    = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Registered from the updated count, so the gate is already low in
      // the cycle that would otherwise exceed the outstanding limit.
      aw_en_d = (state_d == ST_GRANT) && (w_pend_d < WP_MAX);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         sel_q       <= 1'b0;
         last_sel_q  <= 1'b1;
         aw_en_q     <= 1'b0;
         err_q       <= 1'b0;
         w_pend_q    <= '0;
         burst_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         last_sel_q  <= last_sel_d;
         aw_en_q     <= aw_en_d;
         err_q       <= err_d;
         w_pend_q    <= w_pend_d;
         burst_cnt_q <= burst_cnt_d;
      end
   end

   assign sel   = sel_q;
   assign aw_en = aw_en_q;
   assign busy  = (state_q != ST_IDLE);
   assign err   = err_q;

endmodule

// File: tb/tb_axi_wr_arb_2to1.sv
`timescale 1ns/1ps
module tb_axi_wr_arb_2to1;

   localparam int MAXB = 4;
   localparam int MAXO = 3;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic s00_awvalid = 1'b0;
   logic s01_awvalid = 1'b0;
   logic m_awready   = 1'b0;
   logic m_wvalid    = 1'b0;
   logic m_wready    = 1'b0;
   logic m_wlast     = 1'b0;
   logic m_bvalid    = 1'b0;
   logic sel, aw_en, busy, err;

   always #5 clk = ~clk;

   axi_wr_arb_2to1 #(
      .C_MAX_BURSTS      (MAXB),
      .C_MAX_OUTSTANDING (MAXO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .s00_awvalid (s00_awvalid),
      .s01_awvalid (s01_awvalid),
      .m_awready   (m_awready),
      .m_wvalid    (m_wvalid),
      .m_wready    (m_wready),
      .m_wlast     (m_wlast),
      .m_bvalid    (m_bvalid),
      .sel         (sel),
      .aw_en       (aw_en),
      .busy        (busy),
      .err         (err)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: who owns the port, how many bursts the tenure may
   // still issue, and pending work as totals accepted minus totals retired.
   bit md_sel, md_en, md_busy, md_err, md_last;
   bit md_owner, md_drain;
   int md_left;
   int md_aw_total, md_w_total;
   int md_bp;

   task automatic check(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s @%0t: observed %b expected %b", tag, $time, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".sel"},   sel,   md_sel);
      check({tag, ".aw_en"}, aw_en, md_en);
      check({tag, ".busy"},  busy,  md_busy);
      check({tag, ".err"},   err,   md_err);
   endtask

   task automatic model_reset();
      md_sel = 0; md_en = 0; md_busy = 0; md_err = 0; md_last = 1;
      md_owner = 0; md_drain = 0; md_left = 0;
      md_aw_total = 0; md_w_total = 0; md_bp = 0;
   endtask

   function automatic int pending();
      return md_aw_total - md_w_total;
   endfunction

   task automatic drive(input bit s0, input bit s1, input bit awr,
                        input bit wv, input bit wr, input bit wl, input bit bv);
      s00_awvalid = s0; s01_awvalid = s1; m_awready = awr;
      m_wvalid = wv; m_wready = wr; m_wlast = wl; m_bvalid = bv;
   endtask

   // Predict the next cycle from current inputs, clock, then compare.
   task automatic tick(input string tag);
      bit cur, oth, awhs, whs, bhs, bp_ok;
      bit owner_n, drain_n, sel_n, last_n, err_n;
      int left_n, pend, bp_n;
      cur  = md_sel ? s01_awvalid : s00_awvalid;
      oth  = md_sel ? s00_awvalid : s01_awvalid;
      awhs = md_en && cur && m_awready;
      whs  = m_wvalid && m_wready && m_wlast;
      bhs  = m_bvalid;
      pend = pending();
      err_n = md_err;
      bp_n  = md_bp;
      if (awhs) md_aw_total++;
      if (whs) begin
         if (pend == 0 && !awhs) err_n = 1;
         else md_w_total++;
      end
`ifdef AXI_WR_ARB_BRESP_WAIT_EN
      if (whs && !bhs) bp_n = md_bp + 1;
      else if (bhs && !whs) begin
         if (md_bp == 0) err_n = 1;
         else bp_n = md_bp - 1;
      end
      bp_ok = (md_bp == 0);
`else
      bp_ok = 1;
      if (bhs) bp_n = 0;
`endif
      owner_n = md_owner; drain_n = md_drain; sel_n = md_sel;
      last_n = md_last; left_n = md_left;
      if (!md_owner && !md_drain) begin
         if (s00_awvalid || s01_awvalid) begin
            sel_n   = (s00_awvalid && s01_awvalid) ? !md_last : s01_awvalid;
            owner_n = 1;
            left_n  = MAXB;
         end
      end else if (md_owner) begin
         if (awhs) left_n = md_left - 1;
         if ((awhs && md_left == 1) || (!cur && oth)) begin
            owner_n = 0;
            drain_n = 1;
         end
      end else begin
         if (pend == 0 && bp_ok) begin
            last_n  = md_sel;
            drain_n = 0;
         end
      end
      @(posedge clk);
      #1;
      md_sel = sel_n; md_last = last_n; md_err = err_n; md_bp = bp_n;
      md_owner = owner_n; md_drain = drain_n; md_left = left_n;
      md_en   = owner_n && (pending() < MAXO);
      md_busy = owner_n || drain_n;
      check_all(tag);
   endtask

   task automatic do_reset(input string tag);
      drive(0, 0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      #2;
      model_reset();
      check({tag, ".async_sel"},   sel,   1'b0);
      check({tag, ".async_aw_en"}, aw_en, 1'b0);
      check({tag, ".async_busy"},  busy,  1'b0);
      check({tag, ".async_err"},   err,   1'b0);
      @(posedge clk);
      #1;
      check_all({tag, ".held"});
      rst = 1'b0;
      $display("reset %s done", tag);
   endtask

   initial begin
      int beat;
      int pend;
      int dens0[4];
      int dens1[4];
      dens0 = '{90, 80, 30, 100};
      dens1 = '{90, 20, 30, 100};

      // Step 1: reset, then s00 issues three 3-beat bursts.
      do_reset("por");
      drive(1, 0, 1, 0, 1, 0, 0);
      tick("first_req");
      check("first_sel", sel, 1'b0);
      check("first_aw_en", aw_en, 1'b1);
      beat = 0;
      for (int c = 0; c < 25; c++) begin
         pend = pending();
         s00_awvalid = (md_aw_total < 3);
         m_wvalid    = (pend > 0);
         m_wlast     = (pend > 0) && (beat == 2);
         if (m_wvalid) beat = (beat == 2) ? 0 : beat + 1;
         tick("three_bursts");
      end
      check("three_bursts_err", err, 1'b0);
      check("three_bursts_sel", sel, 1'b0);
      $display("three bursts: accepted %0d retired %0d", md_aw_total, md_w_total);

      // Step 2: outstanding limit with W stalled, then release one wlast.
      do_reset("limit");
      for (int c = 0; c < 6; c++) begin
         drive(1, 0, 1, 1, 0, 1, 0);
         tick("limit_fill");
      end
      check("limit_aw_en_low", aw_en, 1'b0);
      drive(1, 0, 1, 1, 1, 1, 0);
      tick("limit_release");
      check("limit_aw_en_back", aw_en, 1'b1);
      $display("limit: accepted %0d before stall", md_aw_total);

      // Step 3: wlast with nothing accepted raises a sticky error, then a
      // reset in the middle of a tenure with three bursts pending.
      do_reset("err");
      drive(0, 0, 0, 1, 1, 1, 0);
      tick("w_without_aw");
      check("err_set", err, 1'b1);
      for (int c = 0; c < 3; c++) begin
         drive(0, 0, 0, 0, 0, 0, 0);
         tick("err_sticky");
      end
      check("err_still_set", err, 1'b1);
      for (int c = 0; c < 4; c++) begin
         drive(1, 0, 1, 1, 0, 1, 0);
         tick("fill_before_reset");
      end
      $display("mid-grant: %0d bursts pending before reset", pending());
      do_reset("mid_grant");

      // Step 4: randomized traffic at several request densities.
      for (int ph = 0; ph < 4; ph++) begin
         for (int c = 0; c < 600; c++) begin
            pend = pending();
            s00_awvalid = ($urandom_range(0, 99) < dens0[ph]);
            s01_awvalid = ($urandom_range(0, 99) < dens1[ph]);
            m_awready   = ($urandom_range(0, 3) != 0);
            m_wvalid    = ($urandom_range(0, 1) != 0);
            m_wready    = ($urandom_range(0, 2) != 0);
            m_wlast     = (pend > 0) && ($urandom_range(0, 1) != 0);
`ifdef AXI_WR_ARB_BRESP_WAIT_EN
            m_bvalid    = (md_bp > 0) && ($urandom_range(0, 7) == 0);
`else
            m_bvalid    = ($urandom_range(0, 2) == 0);
`endif
            tick("random");
         end
         $display("random phase %0d: accepted %0d retired %0d", ph, md_aw_total, md_w_total);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
